// File: rtl/oam_dma.sv
// Sprite OAM DMA engine: snoops CPU writes to the DMA register, halts the CPU and
// copies one 256-byte page into OAMDATA as alternating read/write bus cycles.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    input  logic [7:0]  bus_din,
    output logic        cpu_rdy,
    output logic        bus_sel,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_dout,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_reg;
    logic       parity;
    logic       trigger;

    // Detection only while IDLE, so stray writes during a transfer (or on the
    // edge that returns to IDLE) are ignored even if the bus mux is bypassed.
    assign trigger = (state == IDLE) && !cpu_rw && (cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            page     <= 8'h00;
            idx      <= 8'h00;
            data_reg <= 8'h00;
            parity   <= 1'b0;
        end else begin
            state  <= state_nxt;
            parity <= ~parity;
            if (trigger) begin
                page <= cpu_dout;
                idx  <= 8'h00;
            end
            if (state == READ) begin
                data_reg <= bus_din;
            end
            if (state == WRITE) begin
                idx <= idx + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cpu_rdy    = 1'b1;
        bus_sel    = 1'b0;
        dma_active = 1'b0;
        dma_rw     = 1'b1;
        dma_addr   = 16'h0000;
        dma_dout   = data_reg;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = HALT;
                end
            end
            HALT, ALIGN: begin
                // Dummy read cycles; ALIGN pushes the first READ onto a get (parity 0) cycle.
                cpu_rdy    = 1'b0;
                bus_sel    = 1'b1;
                dma_active = 1'b1;
                dma_addr   = {page, idx};
                if (state == ALIGN || parity) begin
                    state_nxt = READ;
                end else begin
                    state_nxt = ALIGN;
                end
            end
            READ: begin
                cpu_rdy    = 1'b0;
                bus_sel    = 1'b1;
                dma_active = 1'b1;
                dma_addr   = {page, idx};
                state_nxt  = WRITE;
            end
            WRITE: begin
                cpu_rdy    = 1'b0;
                bus_sel    = 1'b1;
                dma_active = 1'b1;
                dma_rw     = 1'b0;
                dma_addr   = OAMDATA_ADDR;
                state_nxt  = (idx == 8'hFF) ? IDLE : READ;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Randomised bench for oam_dma: a bus-cycle schedule model predicts every output
// on every cycle, plus literal checks on latency, copied bytes and reset values.
module tb_oam_dma;

    logic        clk_ph1 = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_rw = 1'b1;
    logic [7:0]  bus_din;
    logic        cpu_rdy;
    logic        bus_sel;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_dout;
    logic        dma_active;

    oam_dma dut (
        .clk_ph1   (clk_ph1),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_rw    (cpu_rw),
        .bus_din   (bus_din),
        .cpu_rdy   (cpu_rdy),
        .bus_sel   (bus_sel),
        .dma_addr  (dma_addr),
        .dma_rw    (dma_rw),
        .dma_dout  (dma_dout),
        .dma_active(dma_active)
    );

    // ---------------- clock ----------------
    always #5 clk_ph1 = ~clk_ph1;

    // ---------------- memory map ----------------
    logic [7:0] mem_key = 8'hA5;
    assign bus_din = dma_addr[7:0] ^ mem_key;

    // ---------------- behavioural model ----------------
    localparam logic [1:0] K_DUMMY = 2'd0;
    localparam logic [1:0] K_READ  = 2'd1;
    localparam logic [1:0] K_WRITE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [7:0]  idx;
    } op_t;

    op_t        exp_q[$];
    logic       par = 1'b0;
    logic [7:0] last_byte = 8'h00;
    op_t        popped;

    // Each entry is one bus cycle still to come; the front is the current cycle.
    always @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            par       = 1'b0;
            last_byte = 8'h00;
        end else begin
            if (exp_q.size() > 0) begin
                popped = exp_q.pop_front();
                if (popped.kind == K_READ) last_byte = popped.addr[7:0] ^ mem_key;
            end else if (!cpu_rw && cpu_addr == 16'h4014) begin
                exp_q.push_back({K_DUMMY, {cpu_dout, 8'h00}, 8'h00});
                if (par == 1'b1) exp_q.push_back({K_DUMMY, {cpu_dout, 8'h00}, 8'h00});
                for (int i = 0; i < 256; i++) begin
                    exp_q.push_back({K_READ, {cpu_dout, 8'(i)}, 8'(i)});
                    exp_q.push_back({K_WRITE, 16'h2004, 8'(i)});
                end
            end
            par = ~par;
        end
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    int          rdy_low_cnt = 0;
    logic [7:0]  wr_log[$];
    logic [15:0] rd_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    logic        e_rdy, e_sel, e_rw, e_act;
    logic [15:0] e_addr;

    always @(negedge clk_ph1) begin
        if (exp_q.size() == 0) begin
            e_rdy = 1'b1; e_sel = 1'b0; e_rw = 1'b1; e_act = 1'b0; e_addr = 16'h0000;
        end else begin
            e_rdy = 1'b0; e_sel = 1'b1; e_act = 1'b1;
            e_rw   = (exp_q[0].kind != K_WRITE);
            e_addr = exp_q[0].addr;
        end
        checks++;
        if ({cpu_rdy, bus_sel, dma_active, dma_rw, dma_addr, dma_dout} !==
            {e_rdy, e_sel, e_act, e_rw, e_addr, last_byte}) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t actual rdy=%b sel=%b act=%b rw=%b addr=%h dout=%h required rdy=%b sel=%b act=%b rw=%b addr=%h dout=%h",
                     $time, cpu_rdy, bus_sel, dma_active, dma_rw, dma_addr, dma_dout,
                     e_rdy, e_sel, e_act, e_rw, e_addr, last_byte);
        end
        if (!cpu_rdy) rdy_low_cnt++;
        if (bus_sel && !dma_rw) wr_log.push_back(dma_dout);
        if (bus_sel && dma_rw) rd_log.push_back(dma_addr);
    end

    // ---------------- driver tasks ----------------
    // Random CPU-side traffic; a $4014 write is only allowed when it must be ignored.
    task automatic drive_random();
        cpu_addr = 16'($urandom_range(0, 3) == 0 ? 16'h4014 : $urandom);
        cpu_dout = 8'($urandom);
        cpu_rw   = 1'($urandom);
        if (exp_q.size() == 0 && cpu_addr == 16'h4014) cpu_rw = 1'b1;
    endtask

    task automatic step();
        @(posedge clk_ph1);
        #1;
    endtask

    // align: 0 = HALT on parity 0, 1 = HALT on parity 1, 2 = wherever it lands
    task automatic trigger(input logic [7:0] pg, input int align, output int exp_low);
        for (int n = 0; n < 4 && align < 2 && par == align[0]; n++) begin
            drive_random();
            step();
        end
        exp_low  = (par == 1'b0) ? 513 : 514;
        cpu_addr = 16'h4014;
        cpu_rw   = 1'b0;
        cpu_dout = pg;
        rdy_low_cnt = 0;
        wr_log.delete();
        rd_log.delete();
        step();
        drive_random();
    endtask

    task automatic wait_done(input string name, input int exp_low);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 700; n++) begin
            step();
            drive_random();
            if (cpu_rdy) begin
                done = 1'b1;
                break;
            end
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_rdy_low"}, 32'(rdy_low_cnt), 32'(exp_low));
        chk({name, "_writes"}, 32'(wr_log.size()), 32'd256);
    endtask

    // ---------------- main sequence ----------------
    int exp_low;
    int bad;

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            step();
        end
        chk("reset_rdy", 32'(cpu_rdy), 32'd1);
        chk("reset_sel", 32'(bus_sel), 32'd0);
        chk("reset_active", 32'(dma_active), 32'd0);
        chk("reset_rw", 32'(dma_rw), 32'd1);
        chk("reset_addr", 32'(dma_addr), 32'h0000);
        rst = 1'b1;
        drive_random();
        step();

        // Even alignment: HALT on parity 0, ALIGN cycle present.
        mem_key = 8'hA5;
        trigger(8'h02, 0, exp_low);
        wait_done("even", 514);
        chk("even_first_byte", 32'(wr_log[0]), 32'hA5);
        chk("even_last_byte", 32'(wr_log[255]), 32'h5A);
        chk("even_reads", 32'(rd_log.size()), 32'd258);
        chk("even_first_read", 32'(rd_log[2]), 32'h0200);
        chk("even_last_read", 32'(rd_log[257]), 32'h02FF);

        // Odd alignment: HALT on parity 1, no ALIGN.
        trigger(8'h02, 1, exp_low);
        wait_done("odd", 513);
        chk("odd_reads", 32'(rd_log.size()), 32'd257);
        chk("odd_first_read", 32'(rd_log[1]), 32'h0200);
        chk("odd_byte_80", 32'(wr_log[128]), 32'h25);

        // Non-trigger accesses.
        cpu_addr = 16'h4014; cpu_rw = 1'b1; cpu_dout = 8'h33;
        step();
        cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_dout = 8'h44;
        step();
        drive_random();
        step();
        chk("nontrig_rdy", 32'(cpu_rdy), 32'd1);
        chk("nontrig_active", 32'(dma_active), 32'd0);

        // Abort during WRITE of idx 0x64, then a fresh transfer.
        mem_key = 8'($urandom);
        trigger(8'h07, 2, exp_low);
        for (int n = 0; n < 600; n++) begin
            if (exp_q.size() > 0 && exp_q[0].kind == K_WRITE && exp_q[0].idx == 8'h64) break;
            step();
            drive_random();
        end
        chk("abort_reached", 32'(dma_rw), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_rdy", 32'(cpu_rdy), 32'd1);
        chk("abort_sel", 32'(bus_sel), 32'd0);
        chk("abort_rw", 32'(dma_rw), 32'd1);
        chk("abort_addr", 32'(dma_addr), 32'h0000);
        chk("abort_dout", 32'(dma_dout), 32'h00);
        step();
        step();
        rst = 1'b1;
        drive_random();
        step();
        trigger(8'h03, 2, exp_low);
        wait_done("restart", exp_low);
        chk("restart_first_read", 32'(rd_log[0]), 32'h0300);
        chk("restart_first_byte", 32'(wr_log[0]), 32'(mem_key));

        // Page FF, then back-to-back trigger right after returning to IDLE.
        trigger(8'hFF, 2, exp_low);
        wait_done("pageff", exp_low);
        chk("pageff_last_read", 32'(rd_log[rd_log.size() - 1]), 32'hFFFF);
        bad = 0;
        foreach (rd_log[i]) if (rd_log[i][15:8] != 8'hFF) bad++;
        chk("pageff_no_wrap", 32'(bad), 32'd0);
        trigger(8'h5C, 2, exp_low);
        wait_done("b2b", exp_low);
        chk("b2b_last_read", 32'(rd_log[rd_log.size() - 1]), 32'h5CFF);

        // Random transfers.
        for (int t = 0; t < 6; t++) begin
            mem_key = 8'($urandom);
            for (int g = $urandom_range(0, 5); g > 0; g--) begin
                drive_random();
                step();
            end
            trigger(8'($urandom), 2, exp_low);
            wait_done("random", exp_low);
        end

        for (int i = 0; i < 4; i++) begin
            drive_random();
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite OAM DMA engine on the CPU-side bus, directly downstream of the CPU's address, data and R/W outputs.
- Snoops CPU writes to $4014. On a write it halts the CPU through cpu_rdy and takes over the bus.
- Copies 256 bytes from page {written value, 00..FF} to OAMDATA ($2004), one read/write pair per byte.
- The bus mux selects DMA or CPU drive using bus_sel.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- OAMDATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- clk_ph1  input  1  single CPU-cycle clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- cpu_addr  input  16  CPU address bus
- cpu_dout  input  8  CPU write data
- cpu_rw  input  1  CPU R/W, 1=read, 0=write
- bus_din  input  8  data returned by the memory map for the current bus cycle
- cpu_rdy  output  1  0 = CPU must hold all internal state this cycle
- bus_sel  output  1  1 = DMA drives address/data/R/W
- dma_addr  output  16  DMA address
- dma_rw  output  1  DMA R/W, 1=read, 0=write
- dma_dout  output  8  DMA write data
- dma_active  output  1  1 while transfer in progress (debug/status)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, page=00, idx=00, data_reg=00, parity=0.
  - Outputs: cpu_rdy=1, bus_sel=0, dma_addr=0000, dma_rw=1, dma_dout=00, dma_active=0.
- Parity:
  - 1-bit register, toggles every clk_ph1 edge while rst=1, including when IDLE.
  - parity=0 marks a "get" (read) cycle; parity=1 marks a "put" cycle.
- Trigger:
  - In IDLE, a cycle with cpu_rw=0 and cpu_addr==DMA_REG_ADDR latches page<=cpu_dout and idx<=00, and moves to HALT on that edge.
  - A read of DMA_REG_ADDR never triggers.
- States. Outputs are combinational from the state registers:
  - IDLE: cpu_rdy=1, bus_sel=0, dma_active=0, dma_rw=1.
  - HALT: cpu_rdy=0, bus_sel=1, dma_rw=1, dma_addr={page,idx} (dummy read; data ignored). Next state is READ if parity==1 this cycle, otherwise ALIGN.
  - ALIGN: same outputs as HALT (dummy read). Always goes to READ, so every READ falls on parity==0.
  - READ: cpu_rdy=0, bus_sel=1, dma_rw=1, dma_addr={page,idx}. data_reg<=bus_din at the closing edge. Next state is WRITE.
  - WRITE: cpu_rdy=0, bus_sel=1, dma_rw=0, dma_addr=OAMDATA_ADDR, dma_dout=data_reg. idx<=idx+1 (8-bit wrap). Next state is IDLE if idx==FF before the increment, else READ.
- dma_active=1 in every state except IDLE.
- Latency: trigger edge to return to IDLE is 513 cycles if HALT lands on parity 1, and 514 if it lands on parity 0.
  - Counted as HALT + optional ALIGN + 256×(READ+WRITE).
- Boundaries:
  - Source address is {page,idx} only; there is no carry into the page, so page FF ends at FFFF.
  - Writes to DMA_REG_ADDR while not IDLE are ignored; the CPU is halted, but the block is also robust to the bus mux being bypassed.
  - A trigger write on the same edge the FSM returns to IDLE is not seen, because detection happens only while IDLE.
  - After the final WRITE, cpu_rdy=1 in the very next cycle.
  - Reset asserted mid-transfer aborts immediately. All outputs take reset values, with no partial completion.
  - dma_dout during non-WRITE states equals data_reg; it is don't-care for the bus but must be deterministic.
- CPU integration: the CPU gates all register latching with cpu_rdy. A CPU write cycle that triggers completes normally.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> cpu_rdy=1, bus_sel=0, dma_active=0, dma_rw=1, dma_addr=0000.
- Even alignment: write 8'h02 to $4014 with HALT on parity 0; memory returns byte=addr[7:0]^8'hA5 -> ALIGN present; pairs ($0200 R, $2004 W A5) … ($02FF R, $2004 W 5A); cpu_rdy low exactly 514 cycles.
- Odd alignment: same stimulus shifted one cycle -> no ALIGN; cpu_rdy low exactly 513 cycles; first READ on parity 0.
- Non-trigger: CPU read of $4014, and write to $4015 -> state stays IDLE, cpu_rdy stays 1.
- Abort: trigger page 8'h07, assert rst=0 during WRITE for idx=0x64 -> outputs return to reset values asynchronously; after release a new trigger with page 8'h03 starts at $0300.
- Page FF / back-to-back: trigger page 8'hFF -> last read $FFFF, no wrap into $0000; second $4014 write immediately after IDLE starts a fresh 513/514-cycle transfer.
